opb_sw_reg_bank: RTL and testbench

OPB_SW_REG_BANK -- requirements
Module: opb_sw_reg_bank

---
 rtl/opb_sw_reg_bank_pkg.sv | 27 ++
 rtl/opb_sw_reg_bank_if.sv | 29 ++
 rtl/opb_reg_byte_merge.sv | 11 +
 rtl/opb_sw_reg_bank.sv | 177 +++++++++++++++++
 tb/tb_opb_sw_reg_bank.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opb_sw_reg_bank_pkg.sv
// Shared types and helpers for the OPB software register bank.
package opb_sw_reg_bank_pkg;

   localparam int OPB_REG_BYTES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Replace each byte of cur whose enable is set with the matching byte of wdata.
   // be[OPB_REG_BYTES-1] covers the most significant byte.
   function automatic logic [OPB_REG_BYTES*8-1:0] byte_merge(
      input logic [OPB_REG_BYTES*8-1:0] cur,
      input logic [OPB_REG_BYTES*8-1:0] wdata,
      input logic [OPB_REG_BYTES-1:0]   be
   );
      logic [OPB_REG_BYTES*8-1:0] res;
      res = cur;
      for (int b = 0; b < OPB_REG_BYTES; b++) begin
         if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/opb_sw_reg_bank_if.sv
// OPB slave-side bus bundle. Bit 0 of every vector is the MSB, as on OPB.
interface opb_sw_reg_bank_if
   import opb_sw_reg_bank_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = OPB_REG_BYTES*8
);
   logic [0:AWIDTH-1]   OPB_ABus;
   logic [0:DWIDTH/8-1] OPB_BE;
   logic [0:DWIDTH-1]   OPB_DBus;
   logic                OPB_RNW;
   logic                OPB_select;
   logic                OPB_seqAddr;
   logic [0:DWIDTH-1]   Sl_DBus;
   logic                Sl_xferAck;
   logic                Sl_errAck;
   logic                Sl_retry;
   logic                Sl_toutSup;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );
endinterface

// File: rtl/opb_reg_byte_merge.sv
// Per-register byte-lane write merge.
module opb_reg_byte_merge
   import opb_sw_reg_bank_pkg::*;
(
   input  logic [OPB_REG_BYTES*8-1:0] cur,
   input  logic [OPB_REG_BYTES*8-1:0] wdata,
   input  logic [OPB_REG_BYTES-1:0]   be,
   output logic [OPB_REG_BYTES*8-1:0] merged
);
   assign merged = byte_merge(cur, wdata, be);
endmodule

// File: rtl/opb_sw_reg_bank.sv
// OPB software register bank: C_NUM_REGS 32-bit registers behind an OPB slave.
// Build option OPB_REG_BANK_SHADOW_EN: bus writes land in shadow registers and
// reach user_data_out only when the commit address (index C_NUM_REGS) is written.
//
// state   | meaning
// IDLE    | waiting for a select inside the address window
// ACK     | one-cycle transfer acknowledge (write/read data captured on entry)
// WAIT    | transfer done, waiting for the master to drop select
module opb_sw_reg_bank
   import opb_sw_reg_bank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR    = 32'h0100_8200,
   parameter logic [31:0] C_HIGHADDR    = 32'h0100_82FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter int          C_NUM_REGS    = 4,
   parameter logic [31:0] C_RESET_VALUE = 32'h0,
   parameter              C_FAMILY      = "virtex6"
) (
   input  logic                       OPB_Clk,
   input  logic                       OPB_Rst,
   opb_sw_reg_bank_if.slave           bus,
   output logic [C_NUM_REGS*32-1:0]   user_data_out,
   output logic [C_NUM_REGS-1:0]      user_wr_strobe
);

   localparam int            IW   = C_OPB_AWIDTH - 2;
   localparam logic [IW-1:0] NREG = IW'(C_NUM_REGS);

   state_t                      state;
   logic [C_OPB_AWIDTH-1:0]     addr;
   logic [C_OPB_AWIDTH-1:0]     offset;
   logic [IW-1:0]               idx;
   logic [C_OPB_DWIDTH-1:0]     wdata;
   logic [OPB_REG_BYTES-1:0]    be;
   logic                        hit;
   logic                        start;
   logic                        reg_hit;
   logic                        commit_sel;
   logic                        wr_start;
   logic [C_NUM_REGS-1:0]       wr_sel;
   logic [31:0]                 store  [C_NUM_REGS];
   logic [31:0]                 merged [C_NUM_REGS];
   logic [31:0]                 rd_val;
   logic [31:0]                 rdata;
   logic                        xfer_ack;
   logic                        err_ack;
   logic                        unused_ok;

   assign addr    = bus.OPB_ABus;
   assign wdata   = bus.OPB_DBus;
   assign be      = bus.OPB_BE;
   assign offset  = addr - C_BASEADDR;
   assign idx     = offset[C_OPB_AWIDTH-1:2];
   assign hit     = bus.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
   assign start   = (state == ST_IDLE) && hit;
   assign reg_hit = idx < NREG;
   assign wr_start = start && !bus.OPB_RNW && (be != '0) && reg_hit;

`ifdef OPB_REG_BANK_SHADOW_EN
   assign commit_sel = (idx == NREG);
`else
   assign commit_sel = 1'b0;
`endif

   assign bus.Sl_DBus    = rdata;
   assign bus.Sl_xferAck = xfer_ack;
   assign bus.Sl_errAck  = err_ack;
   assign bus.Sl_retry   = 1'b0;
   assign bus.Sl_toutSup = 1'b0;

   // seqAddr and the byte offset inside a word carry no meaning for this slave.
   assign unused_ok = ^{bus.OPB_seqAddr, offset[1:0], C_FAMILY};

   // Select the addressed bus-visible register for reads.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if (idx == IW'(i)) rd_val = store[i];
      end
   end

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
      assign wr_sel[g] = wr_start && (idx == IW'(g));
      opb_reg_byte_merge u_merge (
         .cur    (store[g]),
         .wdata  (wdata),
         .be     (be),
         .merged (merged[g])
      );
   end

   // Bus handshake: one ack per transfer, read data held only during the ack cycle.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         state    <= ST_IDLE;
         xfer_ack <= 1'b0;
         err_ack  <= 1'b0;
         rdata    <= '0;
      end else begin
         xfer_ack <= 1'b0;
         err_ack  <= 1'b0;
         rdata    <= '0;
         case (state)
            ST_IDLE: begin
               if (hit) begin
                  state    <= ST_ACK;
                  xfer_ack <= 1'b1;
                  err_ack  <= !reg_hit && !commit_sel;
                  if (bus.OPB_RNW && reg_hit) rdata <= rd_val;
               end
            end
            ST_ACK:  state <= ST_WAIT;
            ST_WAIT: if (!bus.OPB_select) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef OPB_REG_BANK_SHADOW_EN
   logic [31:0]           active [C_NUM_REGS];
   logic [C_NUM_REGS-1:0] dirty;
   logic                  commit_wr;

   assign commit_wr = start && !bus.OPB_RNW && (be != '0) && commit_sel;

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
      assign user_data_out[32*g +: 32] = active[g];
   end

   // Shadow writes mark the register dirty; a commit publishes every shadow at once.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         for (int i = 0; i < C_NUM_REGS; i++) begin
            store[i]  <= C_RESET_VALUE;
            active[i] <= C_RESET_VALUE;
         end
         dirty          <= '0;
         user_wr_strobe <= '0;
      end else begin
         user_wr_strobe <= '0;
         for (int i = 0; i < C_NUM_REGS; i++) begin
            if (wr_sel[i]) begin
               store[i] <= merged[i];
               dirty[i] <= 1'b1;
            end
         end
         if (commit_wr) begin
            for (int i = 0; i < C_NUM_REGS; i++) active[i] <= store[i];
            user_wr_strobe <= dirty;
            dirty          <= '0;
         end
      end
   end
`else
   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
      assign user_data_out[32*g +: 32] = store[g];
   end

   // Direct mode: bus writes update the user-visible register and strobe it.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         for (int i = 0; i < C_NUM_REGS; i++) store[i] <= C_RESET_VALUE;
         user_wr_strobe <= '0;
      end else begin
         user_wr_strobe <= '0;
         for (int i = 0; i < C_NUM_REGS; i++) begin
            if (wr_sel[i]) begin
               store[i]          <= merged[i];
               user_wr_strobe[i] <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_opb_sw_reg_bank.sv
// Self-checking bench for opb_sw_reg_bank with randomized traffic against a
// word-level model. Honours OPB_REG_BANK_SHADOW_EN when it is defined.
module tb_opb_sw_reg_bank;

   localparam int          NREGS = 4;
   localparam logic [31:0] BASE  = 32'h0100_8200;
   localparam logic [31:0] HIGH  = 32'h0100_82FF;
   localparam logic [31:0] RSTV  = 32'hA5A5_0F0F;
`ifdef OPB_REG_BANK_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic                   clk;
   logic                   rst;
   logic [NREGS*32-1:0]    user_data_out;
   logic [NREGS-1:0]       user_wr_strobe;

   opb_sw_reg_bank_if bus ();

   opb_sw_reg_bank #(
      .C_BASEADDR    (BASE),
      .C_HIGHADDR    (HIGH),
      .C_NUM_REGS    (NREGS),
      .C_RESET_VALUE (RSTV)
   ) dut (
      .OPB_Clk        (clk),
      .OPB_Rst        (rst),
      .bus            (bus),
      .user_data_out  (user_data_out),
      .user_wr_strobe (user_wr_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [31:0]      m_user   [NREGS];
   logic [31:0]      m_shadow [NREGS];
   logic [NREGS-1:0] m_dirty;

   // Observations from the last transfer
   logic               tr_ack, tr_err;
   logic [31:0]        tr_rdata, tr_post_dbus;
   logic [NREGS-1:0]   tr_strobe, tr_post_strobe;
   logic [NREGS*32-1:0] tr_udata;
   int                 tr_lat, tr_pulses;

   function automatic logic [NREGS*32-1:0] model_udata();
      logic [NREGS*32-1:0] v;
      for (int i = 0; i < NREGS; i++) v[32*i +: 32] = m_user[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_user[i]   = RSTV;
         m_shadow[i] = RSTV;
      end
      m_dirty = '0;
   endtask

   // Word-level reference for one acknowledged transfer.
   task automatic model_access(input int idx, input logic [31:0] data, input logic [3:0] be,
                               input logic rnw, output logic exp_err,
                               output logic [31:0] exp_rdata, output logic [NREGS-1:0] exp_strobe);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      exp_err = 1'b0;
      exp_rdata = '0;
      exp_strobe = '0;
      if (idx < NREGS) begin
         if (rnw) begin
            exp_rdata = SHADOW ? m_shadow[idx] : m_user[idx];
         end else if (be != 4'h0) begin
            if (SHADOW) begin
               m_shadow[idx] = (m_shadow[idx] & ~mask) | (data & mask);
               m_dirty[idx]  = 1'b1;
            end else begin
               m_user[idx]     = (m_user[idx] & ~mask) | (data & mask);
               exp_strobe[idx] = 1'b1;
            end
         end
      end else if (SHADOW && idx == NREGS) begin
         if (!rnw && be != 4'h0) begin
            for (int i = 0; i < NREGS; i++) m_user[i] = m_shadow[i];
            exp_strobe = m_dirty;
            m_dirty    = '0;
         end
      end else begin
         exp_err = 1'b1;
      end
   endtask

   // One bus transfer: select held for 6 cycles, then released with idle gap.
   task automatic xfer(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic rnw);
      @(negedge clk);
      bus.OPB_ABus   = addr;
      bus.OPB_DBus   = data;
      bus.OPB_BE     = be;
      bus.OPB_RNW    = rnw;
      bus.OPB_select = 1'b1;
      tr_ack = 1'b0; tr_err = 1'b0; tr_rdata = '0; tr_strobe = '0; tr_udata = '0;
      tr_post_dbus = '1; tr_post_strobe = '1; tr_lat = 0; tr_pulses = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (bus.Sl_xferAck) begin
            tr_pulses++;
            if (!tr_ack) begin
               tr_ack    = 1'b1;
               tr_lat    = c;
               tr_err    = bus.Sl_errAck;
               tr_rdata  = bus.Sl_DBus;
               tr_strobe = user_wr_strobe;
               tr_udata  = user_data_out;
            end
         end
         if (tr_ack && c == tr_lat + 1) begin
            tr_post_dbus   = bus.Sl_DBus;
            tr_post_strobe = user_wr_strobe;
         end
      end
      @(negedge clk);
      bus.OPB_select = 1'b0;
      bus.OPB_RNW    = 1'b1;
      bus.OPB_BE     = 4'h0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({bus.Sl_xferAck, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup} !== 4'b0) begin
         errors++; $display("FAIL reset_flags got %b expected 0000",
            {bus.Sl_xferAck, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup});
      end
      checks++;
      if (bus.Sl_DBus !== 32'h0) begin
         errors++; $display("FAIL reset_dbus got %h expected 0", bus.Sl_DBus);
      end
      checks++;
      if (user_wr_strobe !== '0) begin
         errors++; $display("FAIL reset_strobe got %b expected 0", user_wr_strobe);
      end
      checks++;
      if (user_data_out !== {NREGS{RSTV}}) begin
         errors++; $display("FAIL reset_udata got %h expected %h", user_data_out, {NREGS{RSTV}});
      end
   endtask

   task automatic test_full_write();
      logic e_err; logic [31:0] e_rd; logic [NREGS-1:0] e_stb;
      model_access(1, 32'hDEADBEEF, 4'hF, 1'b0, e_err, e_rd, e_stb);
      xfer(BASE + 32'd4, 32'hDEADBEEF, 4'hF, 1'b0);
      checks++;
      if (tr_lat != 1) begin
         errors++; $display("FAIL full_write_latency got %0d expected 1", tr_lat);
      end
      checks++;
      if (tr_strobe !== (SHADOW ? 4'b0000 : 4'b0010)) begin
         errors++; $display("FAIL full_write_strobe got %b expected %b", tr_strobe, e_stb);
      end
      checks++;
      if (tr_post_strobe !== '0) begin
         errors++; $display("FAIL full_write_strobe_width got %b expected 0", tr_post_strobe);
      end
      checks++;
      if (tr_udata !== model_udata()) begin
         errors++; $display("FAIL full_write_udata got %h expected %h", tr_udata, model_udata());
      end
      if (!SHADOW) begin
         checks++;
         if (tr_udata[63:32] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL full_write_reg1 got %h expected deadbeef", tr_udata[63:32]);
         end
      end
   endtask

   task automatic test_byte_lanes();
      logic e_err; logic [31:0] e_rd; logic [NREGS-1:0] e_stb;
      model_access(0, 32'h0, 4'hF, 1'b0, e_err, e_rd, e_stb);
      xfer(BASE, 32'h0, 4'hF, 1'b0);
      model_access(0, 32'h11223344, 4'b0100, 1'b0, e_err, e_rd, e_stb);
      xfer(BASE, 32'h11223344, 4'b0100, 1'b0);
      model_access(0, 32'h0, 4'h0, 1'b1, e_err, e_rd, e_stb);
      xfer(BASE, 32'h0, 4'h0, 1'b1);
      checks++;
      if (tr_rdata !== 32'h00220000) begin
         errors++; $display("FAIL byte_lane_read got %h expected 00220000", tr_rdata);
      end
      checks++;
      if (tr_post_dbus !== 32'h0) begin
         errors++; $display("FAIL byte_lane_dbus_after_ack got %h expected 0", tr_post_dbus);
      end
      checks++;
      if (user_data_out !== model_udata()) begin
         errors++; $display("FAIL byte_lane_udata got %h expected %h", user_data_out, model_udata());
      end
   endtask

   task automatic test_out_of_range();
      xfer(BASE + 32'(4*NREGS + 4), 32'h0, 4'hF, 1'b1);
      checks++;
      if ({tr_ack, tr_err} !== 2'b11) begin
         errors++; $display("FAIL oor_ack_err got %b expected 11", {tr_ack, tr_err});
      end
      checks++;
      if (tr_rdata !== 32'h0) begin
         errors++; $display("FAIL oor_rdata got %h expected 0", tr_rdata);
      end
      xfer(BASE + 32'(4*NREGS + 8), 32'hFFFF_FFFF, 4'hF, 1'b0);
      checks++;
      if ({tr_ack, tr_err, tr_strobe} !== {2'b11, 4'b0}) begin
         errors++; $display("FAIL oor_write got ack/err/strobe %b expected 110000", {tr_ack, tr_err, tr_strobe});
      end
      checks++;
      if (user_data_out !== model_udata()) begin
         errors++; $display("FAIL oor_udata got %h expected %h", user_data_out, model_udata());
      end
   endtask

   task automatic test_be_zero();
      xfer(BASE + 32'd8, 32'h1234_5678, 4'h0, 1'b0);
      checks++;
      if ({tr_ack, tr_err, tr_strobe} !== {2'b10, 4'b0}) begin
         errors++; $display("FAIL be_zero got ack/err/strobe %b expected 100000", {tr_ack, tr_err, tr_strobe});
      end
      checks++;
      if (user_data_out !== model_udata()) begin
         errors++; $display("FAIL be_zero_udata got %h expected %h", user_data_out, model_udata());
      end
   endtask

   task automatic test_hold_select();
      logic e_err; logic [31:0] e_rd; logic [NREGS-1:0] e_stb;
      model_access(3, 32'h0, 4'h0, 1'b1, e_err, e_rd, e_stb);
      xfer(BASE + 32'd12, 32'h0, 4'h0, 1'b1);
      checks++;
      if (tr_pulses != 1) begin
         errors++; $display("FAIL hold_select_pulses got %0d expected 1", tr_pulses);
      end
      checks++;
      if (tr_rdata !== e_rd) begin
         errors++; $display("FAIL hold_select_rdata got %h expected %h", tr_rdata, e_rd);
      end
   endtask

   task automatic test_reset_midway();
      int acks;
      acks = 0;
      @(negedge clk);
      bus.OPB_ABus   = BASE + 32'd8;
      bus.OPB_DBus   = 32'hCAFE_F00D;
      bus.OPB_BE     = 4'hF;
      bus.OPB_RNW    = 1'b0;
      bus.OPB_select = 1'b1;
      #2 rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (bus.Sl_xferAck) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++; $display("FAIL reset_midway_ack got %0d pulses expected 0", acks);
      end
      checks++;
      if (user_data_out !== {NREGS{RSTV}}) begin
         errors++; $display("FAIL reset_midway_udata got %h expected %h", user_data_out, {NREGS{RSTV}});
      end
      @(negedge clk);
      bus.OPB_select = 1'b0;
      bus.OPB_BE     = 4'h0;
      bus.OPB_RNW    = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
   endtask

`ifdef OPB_REG_BANK_SHADOW_EN
   task automatic test_shadow_commit();
      logic e_err; logic [31:0] e_rd; logic [NREGS-1:0] e_stb;
      model_access(0, 32'd5, 4'hF, 1'b0, e_err, e_rd, e_stb);
      xfer(BASE, 32'd5, 4'hF, 1'b0);
      model_access(2, 32'd7, 4'hF, 1'b0, e_err, e_rd, e_stb);
      xfer(BASE + 32'd8, 32'd7, 4'hF, 1'b0);
      checks++;
      if (user_data_out !== {NREGS{RSTV}}) begin
         errors++; $display("FAIL shadow_precommit got %h expected %h", user_data_out, {NREGS{RSTV}});
      end
      model_access(NREGS, 32'h0, 4'h1, 1'b0, e_err, e_rd, e_stb);
      xfer(BASE + 32'(4*NREGS), 32'h0, 4'h1, 1'b0);
      checks++;
      if ({tr_ack, tr_err, tr_strobe} !== {2'b10, 4'b0101}) begin
         errors++; $display("FAIL shadow_commit got ack/err/strobe %b expected 100101", {tr_ack, tr_err, tr_strobe});
      end
      checks++;
      if (tr_udata[31:0] !== 32'd5 || tr_udata[95:64] !== 32'd7 || tr_udata !== model_udata()) begin
         errors++; $display("FAIL shadow_commit_udata got %h expected %h", tr_udata, model_udata());
      end
   endtask
`endif

   task automatic test_random(input int n);
      for (int t = 0; t < n; t++) begin
         int sel, idx;
         logic [31:0] addr, data;
         logic [3:0] be;
         logic rnw, hit, e_err;
         logic [31:0] e_rd;
         logic [NREGS-1:0] e_stb;
         sel  = int'($urandom_range(0, 11));
         idx  = int'($urandom_range(0, NREGS + 2));
         data = $urandom;
         be   = 4'($urandom_range(0, 15));
         rnw  = 1'($urandom_range(0, 1));
         addr = BASE + 32'(4*idx) + 32'($urandom_range(0, 3));
         hit  = 1'b1;
         if (sel == 0) begin addr = BASE - 32'd4; hit = 1'b0; end
         else if (sel == 1) begin addr = HIGH + 32'd1; hit = 1'b0; end
         e_err = 1'b0; e_rd = '0; e_stb = '0;
         if (hit) model_access(idx, data, be, rnw, e_err, e_rd, e_stb);
         xfer(addr, data, be, rnw);
         if (hit) begin
            checks++;
            if (tr_ack !== 1'b1 || tr_lat != 1 || tr_pulses != 1) begin
               errors++; $display("FAIL rand_ack t=%0d ack=%b lat=%0d pulses=%0d expected 1/1/1", t, tr_ack, tr_lat, tr_pulses);
            end
            checks++;
            if ({tr_err, tr_rdata, tr_strobe} !== {e_err, e_rd, e_stb}) begin
               errors++; $display("FAIL rand_resp t=%0d err/rdata/strobe got %b %h %b expected %b %h %b",
                  t, tr_err, tr_rdata, tr_strobe, e_err, e_rd, e_stb);
            end
            checks++;
            if ({tr_post_dbus, tr_post_strobe} !== '0) begin
               errors++; $display("FAIL rand_after_ack t=%0d dbus=%h strobe=%b expected 0", t, tr_post_dbus, tr_post_strobe);
            end
            checks++;
            if (tr_udata !== model_udata()) begin
               errors++; $display("FAIL rand_udata t=%0d got %h expected %h", t, tr_udata, model_udata());
            end
         end else begin
            checks++;
            if (tr_ack !== 1'b0 || user_data_out !== model_udata()) begin
               errors++; $display("FAIL rand_miss t=%0d ack=%b udata=%h expected 0 %h", t, tr_ack, user_data_out, model_udata());
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.OPB_ABus    = '0;
      bus.OPB_DBus    = '0;
      bus.OPB_BE      = '0;
      bus.OPB_RNW     = 1'b1;
      bus.OPB_select  = 1'b0;
      bus.OPB_seqAddr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      test_reset();
      test_full_write();
      test_byte_lanes();
      test_out_of_range();
      test_be_zero();
      test_hold_select();
      test_reset_midway();
`ifdef OPB_REG_BANK_SHADOW_EN
      test_shadow_commit();
`endif
      test_random(200);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
